// File: rtl/iob_2p_mem_fifo_ctrl.sv
// ============================================================================
//  Module   : iob_2p_mem_fifo_ctrl
//  Purpose  : Single-clock FIFO controller driving both ports of an external
//             2-port memory (registered read, 1-cycle latency). Accepts a
//             valid/ready push stream and presents a first-word-fall-through
//             valid/ready pop stream whose data comes straight from the
//             memory read port.
//  Options  : IOB_2P_MEM_FIFO_CTRL_LEVEL_EN - adds the 'level' output
//             (words in memory plus the head word).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module iob_2p_mem_fifo_ctrl #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              mem_w_en,
    output logic [ADDR_W-1:0] mem_w_addr,
    output logic [DATA_W-1:0] mem_w_data,
    output logic              mem_r_en,
    output logic [ADDR_W-1:0] mem_r_addr,
    input  logic [DATA_W-1:0] mem_r_data
`ifdef IOB_2P_MEM_FIFO_CTRL_LEVEL_EN
    ,
    output logic [ADDR_W:0]   level
`endif
);

    // Output stage: EMPTY means no head word, HEAD means mem data_out is valid
    localparam logic [0:0] c_ST_EMPTY = 1'b0;
    localparam logic [0:0] c_ST_HEAD  = 1'b1;

    localparam logic [ADDR_W:0]   c_DEPTH_CNT = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]   c_CNT_ONE   = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] c_PTR_ONE   = {{(ADDR_W-1){1'b0}}, 1'b1};

    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_mem_cnt;
    logic [0:0]        r_state;
    logic [0:0]        w_state_nxt;

    logic w_full;
    logic w_push;
    logic w_fetch;

    // Handshake and memory-port control; clr masks every side effect.
    // A fetch only targets words counted in mem_cnt, i.e. written on an
    // earlier edge, so a read never collides with the concurrent write.
    always_comb begin
        w_full     = (r_mem_cnt == c_DEPTH_CNT);
        in_ready   = !w_full && !clr;
        w_push     = in_valid && in_ready;
        w_fetch    = (r_mem_cnt != '0) && (!out_valid || out_ready) && !clr;
        mem_w_en   = w_push;
        mem_w_addr = r_wr_ptr;
        mem_w_data = in_data;
        mem_r_en   = w_fetch;
        mem_r_addr = r_rd_ptr;
        out_valid  = (r_state == c_ST_HEAD);
        out_data   = mem_r_data;
    end

    // Output-stage next state: a fetch always (re)loads the head; a pop
    // without a fetch empties it; otherwise the memory holds data_out
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_EMPTY: if (w_fetch) w_state_nxt = c_ST_HEAD;
            c_ST_HEAD:  if (out_ready && !w_fetch) w_state_nxt = c_ST_EMPTY;
            default:    w_state_nxt = c_ST_EMPTY;
        endcase
        if (clr) w_state_nxt = c_ST_EMPTY;
    end

    // Pointer, occupancy and output-stage registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_mem_cnt <= '0;
            r_state   <= c_ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
            if (clr) begin
                r_wr_ptr  <= '0;
                r_rd_ptr  <= '0;
                r_mem_cnt <= '0;
            end else begin
                if (w_push)  r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
                if (w_fetch) r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
                case ({w_push, w_fetch})
                    2'b10:   r_mem_cnt <= r_mem_cnt + c_CNT_ONE;
                    2'b01:   r_mem_cnt <= r_mem_cnt - c_CNT_ONE;
                    default: r_mem_cnt <= r_mem_cnt;
                endcase
            end
        end
    end

`ifdef IOB_2P_MEM_FIFO_CTRL_LEVEL_EN
    // Total occupancy including the head word, up to DEPTH+1
    always_comb begin
        level = r_mem_cnt + {{ADDR_W{1'b0}}, out_valid};
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_iob_2p_mem_fifo_ctrl.sv
// ============================================================================
//  Module   : tb_iob_2p_mem_fifo_ctrl
//  Purpose  : Self-checking bench for iob_2p_mem_fifo_ctrl with a behavioural
//             2-port memory and a queue scoreboard.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_iob_2p_mem_fifo_ctrl;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 6;
    localparam int DEPTH  = 2**ADDR_W;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              clr;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              mem_w_en;
    logic [ADDR_W-1:0] mem_w_addr;
    logic [DATA_W-1:0] mem_w_data;
    logic              mem_r_en;
    logic [ADDR_W-1:0] mem_r_addr;
    logic [DATA_W-1:0] mem_r_data = '0;
`ifdef IOB_2P_MEM_FIFO_CTRL_LEVEL_EN
    logic [ADDR_W:0]   level;
`endif

    iob_2p_mem_fifo_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (clr),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .mem_w_en   (mem_w_en),
        .mem_w_addr (mem_w_addr),
        .mem_w_data (mem_w_data),
        .mem_r_en   (mem_r_en),
        .mem_r_addr (mem_r_addr),
        .mem_r_data (mem_r_data)
`ifdef IOB_2P_MEM_FIFO_CTRL_LEVEL_EN
        ,
        .level      (level)
`endif
    );

    always #5 clk = ~clk;

    // Behavioural 2-port memory with registered read
    logic [DATA_W-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (mem_w_en) mem[mem_w_addr] <= mem_w_data;
        if (mem_r_en) mem_r_data <= mem[mem_r_addr];
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard and expected address pointers
    logic [DATA_W-1:0] sb[$];
    int exp_w = 0;
    int exp_r = 0;

    always @(negedge rst_n) begin
        sb.delete();
        exp_w = 0;
        exp_r = 0;
    end

    // Monitor: inputs change only just after posedge, so values at negedge
    // describe exactly what the coming edge will do
    always @(negedge clk) begin
        if (rst_n) begin
            if (clr) begin
                sb.delete();
                exp_w = 0;
                exp_r = 0;
            end else begin
                if (in_valid && in_ready) begin
                    chk("w_en_on_push", 32'(mem_w_en), 32'd1);
                    chk("w_addr", 32'(mem_w_addr), 32'(exp_w % DEPTH));
                    chk("w_data", 32'(mem_w_data), 32'(in_data));
                    sb.push_back(in_data);
                    exp_w++;
                end else if (in_valid) begin
                    chk("w_en_blocked", 32'(mem_w_en), 32'd0);
                end
                if (mem_r_en) begin
                    chk("r_addr", 32'(mem_r_addr), 32'(exp_r % DEPTH));
                    exp_r++;
                end
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) chk("pop_unexpected", 32'd1, 32'd0);
                    else chk("pop_data", 32'(out_data), 32'(sb.pop_front()));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_words(input int n, input logic [DATA_W-1:0] base);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_data  = base + DATA_W'(i);
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        bit done = 0;
        out_ready = 1'b1;
        for (int k = 0; k < 300 && !done; k++) begin
            @(negedge clk);
            if (!out_valid && !mem_r_en) done = 1;
            tick();
        end
        out_ready = 1'b0;
        chk({tag, "_drain_done"}, 32'(done), 32'd1);
        chk({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int stalls;
        int ovc;
        rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        #22;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_w_en", 32'(mem_w_en), 32'd0);
        chk("rst_r_en", 32'(mem_r_en), 32'd0);
`ifdef IOB_2P_MEM_FIFO_CTRL_LEVEL_EN
        chk("rst_level", 32'(level), 32'd0);
`endif
        #3 rst_n = 1'b1;
        tick();

        // Single word: visible two edges after the accepting edge
        in_valid = 1'b1; in_data = 16'h1234;
        @(negedge clk);
        chk("single_in_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        chk("single_ov_edge1", 32'(out_valid), 32'd0);
        chk("single_fetch", 32'(mem_r_en), 32'd1);
        tick();
        @(negedge clk);
        chk("single_ov_edge2", 32'(out_valid), 32'd1);
        chk("single_data", 32'(out_data), 32'h1234);
        tick();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        @(negedge clk);
        chk("single_ov_after_pop", 32'(out_valid), 32'd0);
        chk("single_r_en_after_pop", 32'(mem_r_en), 32'd0);
        tick();

        // Fill without popping: DEPTH in memory plus one head word
        acc = 0;
        for (int i = 0; i < DEPTH + 6; i++) begin
            in_valid = 1'b1;
            in_data  = 16'h0100 + DATA_W'(acc);
            @(negedge clk);
            if (in_ready) acc++;
            tick();
        end
        chk("fill_accepted", 32'(acc), 32'(DEPTH + 1));
        @(negedge clk);
        chk("fill_in_ready", 32'(in_ready), 32'd0);
        chk("fill_out_valid", 32'(out_valid), 32'd1);
        chk("fill_head", 32'(out_data), 32'h0100);
`ifdef IOB_2P_MEM_FIFO_CTRL_LEVEL_EN
        chk("fill_level", 32'(level), 32'(DEPTH + 1));
`endif
        tick();

        // Full: pop with a push attempt -> no write now, write next cycle
        in_valid = 1'b1; in_data = 16'hBEEF; out_ready = 1'b1;
        @(negedge clk);
        chk("full_pop_in_ready", 32'(in_ready), 32'd0);
        chk("full_pop_w_en", 32'(mem_w_en), 32'd0);
        tick();
        out_ready = 1'b0;
        @(negedge clk);
        chk("freed_in_ready", 32'(in_ready), 32'd1);
        chk("freed_w_en", 32'(mem_w_en), 32'd1);
        tick();
        in_valid = 1'b0;
        drain("full");

        // Wrap-around streaming at one word per cycle
        stalls = 0; ovc = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 200; i++) begin
            in_valid = 1'b1;
            in_data  = DATA_W'(i);
            @(negedge clk);
            if (!in_ready) stalls++;
            if (out_valid) ovc++;
            tick();
        end
        in_valid = 1'b0;
        chk("stream_stalls", 32'(stalls), 32'd0);
        chk("stream_ov_cycles", 32'(ovc), 32'd198);
        drain("stream");

        // Backpressure: head holds, no fetch while stalled
        out_ready = 1'b0;
        push_words(3, 16'h0005);
        tick();
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("bp_head", 32'(out_data), 32'h0005);
            chk("bp_r_en", 32'(mem_r_en), 32'd0);
            tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        @(negedge clk);
        chk("bp_next_valid", 32'(out_valid), 32'd1);
        chk("bp_next_data", 32'(out_data), 32'h0006);
        tick();
        drain("bp");

        // clr with a push attempt
        push_words(10, 16'h0200);
        tick();
        clr = 1'b1; in_valid = 1'b1; in_data = 16'hDEAD;
        @(negedge clk);
        chk("clr_in_ready", 32'(in_ready), 32'd0);
        chk("clr_w_en", 32'(mem_w_en), 32'd0);
        chk("clr_r_en", 32'(mem_r_en), 32'd0);
        tick();
        clr = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("clr_out_valid", 32'(out_valid), 32'd0);
        chk("clr_in_ready_after", 32'(in_ready), 32'd1);
        chk("clr_r_en_after", 32'(mem_r_en), 32'd0);
`ifdef IOB_2P_MEM_FIFO_CTRL_LEVEL_EN
        chk("clr_level", 32'(level), 32'd0);
`endif
        tick();
        drain("clr");

        // Asynchronous reset mid-cycle
        push_words(5, 16'h0300);
        tick();
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_in_ready", 32'(in_ready), 32'd1);
        chk("arst_r_en", 32'(mem_r_en), 32'd0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        tick();
        push_words(1, 16'h4321);
        drain("arst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
